stack_sequencer: RTL

Data-stack controller that drives the stack memory's read and write ports for the Forth core. It holds the stack pointer and accepts one stack operation at a time over a valid/ready handshake. Each operation becomes a sequence of memory write cycles plus a settle cycle, so the memory's registered TOS/NOS outputs are current whenever the sequencer is ready. It is the initiator on the same address/data/write interface the stack memory responds to.

---
 rtl/stack_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/stack_sequencer.sv
// Data-stack controller for the Forth core: owns the stack pointer and turns each
// accepted stack operation into memory write cycles followed by a TOS/NOS settle cycle.
module stack_sequencer #(
   parameter int          DEPTH = 64,
   parameter logic [15:0] BASE  = 16'h0000
) (
   input  logic                    c_CLOCK,
   input  logic                    c_RESET,
   input  logic                    i_VALID,
   input  logic [2:0]              i_OPCODE,
   input  logic [15:0]             i_PUSHDATA,
   output logic                    o_READY,
   output logic                    o_DONE,
   output logic                    o_ERR,
   output logic [$clog2(DEPTH):0]  o_DEPTH,
   output logic [15:0]             o_RADDR,
   output logic [15:0]             o_WADDR,
   output logic [15:0]             o_DATA,
   output logic                    f_WRITE,
   input  logic [15:0]             i_OP1,
   input  logic [15:0]             i_OP2
);

   localparam int SPW = $clog2(DEPTH) + 1;
   localparam logic [SPW-1:0] FULL = SPW'(DEPTH);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WR_A   = 2'd1;
   localparam logic [1:0] S_WR_B   = 2'd2;
   localparam logic [1:0] S_SETTLE = 2'd3;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_DROP = 3'd2;
   localparam logic [2:0] OP_DUP  = 3'd3;
   localparam logic [2:0] OP_SWAP = 3'd4;
   localparam logic [2:0] OP_OVER = 3'd5;

   logic [1:0]     r_state;
   logic [SPW-1:0] r_sp;
   logic [2:0]     r_op;
   logic [15:0]    r_t;
   logic           r_ready, r_done, r_err, r_write;
   logic [15:0]    r_raddr, r_waddr, r_data;

   logic [1:0]     w_state;
   logic [SPW-1:0] w_sp;
   logic           w_legal, w_write, w_done, w_err;
   logic [15:0]    w_waddr, w_data, w_raddr, w_sp16, w_nsp16;

   always_comb begin
      w_sp16 = 16'(r_sp);
      case (i_OPCODE)
         OP_NOP:  w_legal = 1'b1;
         OP_PUSH: w_legal = (r_sp != FULL);
         OP_DROP: w_legal = (r_sp != '0);
         OP_DUP:  w_legal = (r_sp != '0) && (r_sp != FULL);
         OP_SWAP: w_legal = (r_sp >= SPW'(2));
         OP_OVER: w_legal = (r_sp >= SPW'(2)) && (r_sp != FULL);
         default: w_legal = 1'b0;
      endcase
   end

   // Next-cycle output values are computed here so every port comes straight off a flop.
   always_comb begin
      w_state = r_state;
      w_sp    = r_sp;
      w_write = 1'b0;
      w_waddr = r_waddr;
      w_data  = r_data;
      w_done  = 1'b0;
      w_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_VALID) begin
               if (!w_legal) begin
                  w_err = 1'b1;
               end else begin
                  case (i_OPCODE)
                     OP_NOP:  w_done = 1'b1;
                     OP_DROP: begin
                        w_sp    = r_sp - SPW'(1);
                        w_state = S_SETTLE;
                     end
                     OP_SWAP: begin
                        w_state = S_WR_A;
                        w_write = 1'b1;
                        w_waddr = BASE + w_sp16 - 16'd1;
                        w_data  = i_OP2;
                     end
                     default: begin
                        w_state = S_WR_A;
                        w_write = 1'b1;
                        w_waddr = BASE + w_sp16;
                        w_data  = (i_OPCODE == OP_PUSH) ? i_PUSHDATA :
                                  (i_OPCODE == OP_DUP)  ? i_OP1 : i_OP2;
                     end
                  endcase
               end
            end
         end
         S_WR_A: begin
            if (r_op == OP_SWAP) begin
               w_state = S_WR_B;
               w_write = 1'b1;
               w_waddr = BASE + w_sp16 - 16'd2;
               w_data  = r_t;
            end else begin
               w_sp    = r_sp + SPW'(1);
               w_state = S_SETTLE;
            end
         end
         S_WR_B: w_state = S_SETTLE;
         default: begin
            w_state = S_IDLE;
            w_done  = 1'b1;
         end
      endcase
      w_nsp16 = 16'(w_sp);
      w_raddr = (w_sp == '0) ? BASE : BASE + w_nsp16 - 16'd1;
   end

   always_ff @(posedge c_CLOCK or posedge c_RESET) begin
      if (c_RESET) begin
         r_state <= S_IDLE;
         r_sp    <= '0;
         r_op    <= '0;
         r_t     <= '0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_write <= 1'b0;
         r_raddr <= BASE;
         r_waddr <= '0;
         r_data  <= '0;
      end else begin
         if (r_state == S_IDLE && i_VALID) begin
            r_op <= i_OPCODE;
            r_t  <= i_OP1;
         end
         r_state <= w_state;
         r_sp    <= w_sp;
         r_ready <= (w_state == S_IDLE);
         r_done  <= w_done;
         r_err   <= w_err;
         r_write <= w_write;
         r_raddr <= w_raddr;
         r_waddr <= w_waddr;
         r_data  <= w_data;
      end
   end

   assign o_READY = r_ready;
   assign o_DONE  = r_done;
   assign o_ERR   = r_err;
   assign o_DEPTH = r_sp;
   assign o_RADDR = r_raddr;
   assign o_WADDR = r_waddr;
   assign o_DATA  = r_data;
   assign f_WRITE = r_write;

endmodule
